// File: rtl/conv_tile_sequencer.sv
// Feeds the four stride-1 3x3 windows of a 4x4 tile to conv_kernal and
// gathers the four pipelined results into a 2x2 ofmap.
module conv_tile_sequencer #(
    parameter int DATA_W     = 16,
    parameter int KERNEL_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*DATA_W-1:0]  in_ifmap,
    input  logic [9*DATA_W-1:0]   in_weight,
    output logic [9*DATA_W-1:0]   win_o,
    output logic [9*DATA_W-1:0]   weight_o,
    output logic                  win_valid_o,
    input  logic [DATA_W-1:0]     kern_result_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DATA_W-1:0]   out_ofmap,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;

    state_e                       state_q, state_d;
    logic [16*DATA_W-1:0]         tile_q, tile_d;
    logic [9*DATA_W-1:0]          weight_q, weight_d;
    logic [9*DATA_W-1:0]          win_q, win_d;
    logic                         win_valid_q, win_valid_d;
    logic [1:0]                   win_idx_q, win_idx_d;
    logic [KERNEL_LAT-1:0]        tag_v_q, tag_v_d;
    logic [KERNEL_LAT-1:0][1:0]   tag_idx_q, tag_idx_d;
    logic [4*DATA_W-1:0]          ofmap_q, ofmap_d;
    logic                         out_valid_q, out_valid_d;
    logic                         in_ready_q, in_ready_d;
    logic                         busy_q, busy_d;

    // Window k has origin row k[1], column k[0]; element j = tile[(r+j/3)*4 + c + j%3].
    function automatic logic [9*DATA_W-1:0] window_of(input logic [16*DATA_W-1:0] t,
                                                      input logic [1:0] k);
        logic [9*DATA_W-1:0] w;
        int unsigned         e;
        w = '0;
        for (int unsigned j = 0; j < 9; j++) begin
            e = (32'(k[1]) + j / 3) * 4 + 32'(k[0]) + j % 3;
            w[j*DATA_W +: DATA_W] = t[e*DATA_W +: DATA_W];
        end
        return w;
    endfunction

    always_comb begin
        state_d     = state_q;
        tile_d      = tile_q;
        weight_d    = weight_q;
        win_d       = '0;
        win_valid_d = 1'b0;
        win_idx_d   = win_idx_q;
        ofmap_d     = ofmap_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        // Tag pipeline mirrors the kernel latency so each result lands in its own slot.
        tag_v_d[0]   = win_valid_q;
        tag_idx_d[0] = win_idx_q;
        for (int unsigned i = 1; i < KERNEL_LAT; i++) begin
            tag_v_d[i]   = tag_v_q[i-1];
            tag_idx_d[i] = tag_idx_q[i-1];
        end
        if (tag_v_q[KERNEL_LAT-1]) begin
            ofmap_d[32'(tag_idx_q[KERNEL_LAT-1])*DATA_W +: DATA_W] = kern_result_i;
        end

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    tile_d      = in_ifmap;
                    weight_d    = in_weight;
                    win_idx_d   = 2'd0;
                    win_d       = window_of(in_ifmap, 2'd0);
                    win_valid_d = 1'b1;
                    in_ready_d  = 1'b0;
                    state_d     = FEED;
                end
            end
            FEED: begin
                if (win_idx_q == 2'd3) begin
                    state_d = DRAIN;
                end else begin
                    win_idx_d   = win_idx_q + 2'd1;
                    win_d       = window_of(tile_q, win_idx_d);
                    win_valid_d = 1'b1;
                end
            end
            DRAIN: begin
                if (tag_v_q[KERNEL_LAT-1] && tag_idx_q[KERNEL_LAT-1] == 2'd3) begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tile_q      <= '0;
            weight_q    <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            win_idx_q   <= 2'd0;
            tag_v_q     <= '0;
            tag_idx_q   <= '0;
            ofmap_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tile_q      <= tile_d;
            weight_q    <= weight_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            win_idx_q   <= win_idx_d;
            tag_v_q     <= tag_v_d;
            tag_idx_q   <= tag_idx_d;
            ofmap_q     <= ofmap_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign win_o       = win_q;
    assign weight_o    = weight_q;
    assign win_valid_o = win_valid_q;
    assign out_valid   = out_valid_q;
    assign out_ofmap   = ofmap_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Bench for conv_tile_sequencer: three instances (KERNEL_LAT 2, 1, 4) with
// window-centre stub kernels, checked against a tile-level reference model.
module tb_conv_tile_sequencer;

    localparam int DW = 16;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              in_valid_a  [NI];
    logic [16*DW-1:0]  ifmap_a     [NI];
    logic [9*DW-1:0]   weight_a    [NI];
    logic              out_ready_a [NI];
    logic              in_ready_a  [NI];
    logic [9*DW-1:0]   win_a       [NI];
    logic [9*DW-1:0]   wo_a        [NI];
    logic              winv_a      [NI];
    logic [DW-1:0]     kres_a      [NI];
    logic              outv_a      [NI];
    logic [4*DW-1:0]   ofm_a       [NI];
    logic              busy_a      [NI];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0;
    int miss = 0;
    int last_e0 [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        logic [DW-1:0] dl [L];

        conv_tile_sequencer #(.DATA_W(DW), .KERNEL_LAT(L)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .in_valid      (in_valid_a[g]),
            .in_ready      (in_ready_a[g]),
            .in_ifmap      (ifmap_a[g]),
            .in_weight     (weight_a[g]),
            .win_o         (win_a[g]),
            .weight_o      (wo_a[g]),
            .win_valid_o   (winv_a[g]),
            .kern_result_i (kres_a[g]),
            .out_valid     (outv_a[g]),
            .out_ready     (out_ready_a[g]),
            .out_ofmap     (ofm_a[g]),
            .busy          (busy_a[g])
        );

        // Stub kernel: returns the window centre L cycles after presentation.
        always @(posedge clk) begin
            dl[0] <= win_a[g][4*DW +: DW];
            for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
        end
        assign kres_a[g] = dl[L-1];
    end

    function automatic int lat_of(input int n);
        return (n == 0) ? 2 : ((n == 1) ? 1 : 4);
    endfunction

    function automatic logic [DW-1:0] el(input logic [16*DW-1:0] t, input int row, input int col);
        return t[(row*4 + col)*DW +: DW];
    endfunction

    function automatic logic [9*DW-1:0] exp_win(input logic [16*DW-1:0] t, input int k);
        logic [9*DW-1:0] w;
        for (int i = 0; i < 3; i++)
            for (int jj = 0; jj < 3; jj++)
                w[(i*3 + jj)*DW +: DW] = el(t, k/2 + i, k%2 + jj);
        return w;
    endfunction

    function automatic logic [4*DW-1:0] exp_ofmap(input logic [16*DW-1:0] t);
        logic [4*DW-1:0] o;
        for (int k = 0; k < 4; k++) o[k*DW +: DW] = el(t, k/2 + 1, k%2 + 1);
        return o;
    endfunction

    function automatic logic [16*DW-1:0] rnd_tile();
        logic [16*DW-1:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom();
        return t;
    endfunction

    function automatic logic [9*DW-1:0] rnd_wt();
        logic [159:0] w;
        for (int i = 0; i < 5; i++) w[i*32 +: 32] = $urandom();
        return w[9*DW-1:0];
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int n);
        check("rst_in_ready",  256'(in_ready_a[n]), 256'(1));
        check("rst_out_valid", 256'(outv_a[n]),     256'(0));
        check("rst_win_valid", 256'(winv_a[n]),     256'(0));
        check("rst_busy",      256'(busy_a[n]),     256'(0));
        check("rst_ofmap",     256'(ofm_a[n]),      256'(0));
        check("rst_win_o",     256'(win_a[n]),      256'(0));
        check("rst_weight_o",  256'(wo_a[n]),       256'(0));
    endtask

    // One transaction on instance n; called at a negedge with the instance idle.
    task automatic run_txn(input int n, input logic [16*DW-1:0] tile,
                           input logic [9*DW-1:0] wt, input int hold, input bit chk_gap);
        int              e0;
        int              cnt;
        logic [4*DW-1:0] exp_o;
        exp_o = exp_ofmap(tile);
        out_ready_a[n] = (hold == 0);
        check("idle_in_ready", 256'(in_ready_a[n]), 256'(1));
        in_valid_a[n] = 1'b1;
        ifmap_a[n]    = tile;
        weight_a[n]   = wt;
        e0 = cyc + 1;
        if (chk_gap) check("e0_gap", 256'(e0 - last_e0[n]), 256'(6 + lat_of(n)));
        last_e0[n] = e0;
        @(negedge clk);
        in_valid_a[n] = 1'b0;
        ifmap_a[n]    = rnd_tile();
        weight_a[n]   = rnd_wt();
        for (int k = 0; k < 4; k++) begin
            check("win_valid", 256'(winv_a[n]), 256'(1));
            check("win_o",     256'(win_a[n]),  256'(exp_win(tile, k)));
            check("weight_o",  256'(wo_a[n]),   256'(wt));
            check("busy_feed", 256'(busy_a[n]), 256'(1));
            @(negedge clk);
        end
        check("win_cleared", 256'({winv_a[n], win_a[n]}), 256'(0));
        cnt = 5;
        while (outv_a[n] !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("done_cycle",  256'(cnt),      256'(5 + lat_of(n)));
        check("ofmap",       256'(ofm_a[n]), 256'(exp_o));
        check("weight_hold", 256'(wo_a[n]),  256'(wt));
        for (int h = 0; h < hold; h++) begin
            in_valid_a[n] = 1'($urandom_range(0, 1));
            ifmap_a[n]    = rnd_tile();
            @(negedge clk);
            check("bp_out_valid", 256'(outv_a[n]),     256'(1));
            check("bp_ofmap",     256'(ofm_a[n]),      256'(exp_o));
            check("bp_in_ready",  256'(in_ready_a[n]), 256'(0));
        end
        in_valid_a[n]  = 1'b0;
        out_ready_a[n] = 1'b1;
        @(negedge clk);
        check("post_out_valid", 256'(outv_a[n]),     256'(0));
        check("post_in_ready",  256'(in_ready_a[n]), 256'(1));
        check("ofmap_keep",     256'(ofm_a[n]),      256'(exp_o));
        check("post_busy",      256'(busy_a[n]),     256'(0));
    endtask

    initial begin
        logic [16*DW-1:0] tile_d;
        rst_n = 1'b0;
        for (int n = 0; n < NI; n++) begin
            in_valid_a[n]  = 1'b0;
            ifmap_a[n]     = '0;
            weight_a[n]    = '0;
            out_ready_a[n] = 1'b0;
            last_e0[n]     = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < NI; n++) chk_reset(n);

        for (int e = 0; e < 16; e++) tile_d[e*DW +: DW] = 16'(e);
        run_txn(0, tile_d, rnd_wt(), 0, 1'b0);
        check("dir_ofmap", 256'(ofm_a[0]), 256'({16'h000A, 16'h0009, 16'h0006, 16'h0005}));

        run_txn(0, rnd_tile(), rnd_wt(), 10, 1'b0);

        for (int n = 0; n < NI; n++) begin
            run_txn(n, rnd_tile(), rnd_wt(), 0, 1'b0);
            run_txn(n, rnd_tile(), rnd_wt(), 0, 1'b1);
        end

        // Abort during window 2, then confirm the aborted tile never completes.
        out_ready_a[0] = 1'b1;
        in_valid_a[0]  = 1'b1;
        ifmap_a[0]     = rnd_tile();
        weight_a[0]    = rnd_wt();
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_feed", 256'(winv_a[0]), 256'(1));
        rst_n = 1'b0;
        #1;
        chk_reset(0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_valid", 256'(outv_a[0]), 256'(0));
        end
        run_txn(0, rnd_tile(), rnd_wt(), 0, 1'b0);

        for (int i = 0; i < 6; i++)
            run_txn(int'($urandom_range(0, NI-1)), rnd_tile(), rnd_wt(),
                    int'($urandom_range(0, 3)), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/conv_tile_sequencer.md
Name: conv_tile_sequencer

Overview:
- Initiator side of the conv_kernal datapath: accepts one 4x4 FP16 ifmap tile plus one 3x3 FP16 weight set per transaction.
- Presents the four stride-1 3x3 windows to the kernel on consecutive cycles, then gathers the four pipelined results into a 2x2 ofmap.
- Replaces the hand-sequenced window feeding and result sampling currently done in benches; sits between the tile buffer and conv_kernal inside the accelerator.

Parameters:
- DATA_W, 16, element width (FP16 bit pattern, passed through untouched).
- KERNEL_LAT, 2, cycles from window presentation to the matching conv_kernal result (legal range 1..8).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  tile/weight transaction offered
- in_ready  out  1  block can accept a transaction
- in_ifmap  in  16*DATA_W  4x4 tile, element e = row*4+col at bits [e*DATA_W +: DATA_W]
- in_weight  in  9*DATA_W  3x3 weights, element j at [j*DATA_W +: DATA_W]
- win_o  out  9*DATA_W  current window to conv_kernal
- weight_o  out  9*DATA_W  registered weights to conv_kernal
- win_valid_o  out  1  win_o carries a live window this cycle
- kern_result_i  in  DATA_W  conv_kernal result
- out_valid  out  1  ofmap complete
- out_ready  in  1  consumer takes ofmap
- out_ofmap  out  4*DATA_W  result k at [k*DATA_W +: DATA_W]
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0 except in_ready, which is 1 (state IDLE). Tile, weight, ofmap and tag pipeline registers are cleared.
- Asserting rst_n low mid-transaction aborts immediately. No partial ofmap is ever flagged valid.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at edge E0: latch in_ifmap and in_weight, go to FEED, win_idx = 0.
- FEED:
  - Exactly 4 cycles, win_idx 0..3; win_valid_o = 1 throughout.
  - Window k has origin r = k>>1, c = k&1. Element j of win_o = tile[(r + j/3)*4 + c + j%3].
  - win_o and win_valid_o are registered: window 0 is visible in the first cycle after E0.
  - After win_idx 3, go to DRAIN. win_o returns to 0 and win_valid_o to 0.
- Result capture:
  - A KERNEL_LAT-deep shift register carries {valid, idx} for each presented window.
  - When its head is valid, kern_result_i is written into out_ofmap[idx] at that cycle's closing edge.
  - Result k is captured during cycle (k+1+KERNEL_LAT) after E0.
- DRAIN: wait until idx 3 has been captured, then go to DONE.
- DONE:
  - out_valid = 1, from cycle 5+KERNEL_LAT after E0 (cycle 7 for the default).
  - out_ofmap is held stable while out_valid && !out_ready.
  - On out_valid && out_ready: go to IDLE. out_valid drops and in_ready rises the next cycle.
  - out_ofmap keeps its last value until the next capture overwrites it.
- No overlap of transactions. in_valid while in_ready = 0 is ignored, and in_ifmap changes outside acceptance have no effect.
- weight_o is stable from the cycle after E0 until the next acceptance.
- Back-to-back throughput: one transaction per 6+KERNEL_LAT cycles when out_ready is held high.
- No arithmetic on data. Values are routed bit-exact; width rules apply to indices only (win_idx 2 bits, tags 2 bits).

Test Plan:
- Reset and idle: hold rst_n = 0 for 3 cycles, then release. Required: in_ready = 1, out_valid = 0, win_valid_o = 0, busy = 0, and out_ofmap = 0.
- Window mapping:
  - Stimulus: in_ifmap element e = e (raw 16'h0000..16'h000F), stub kernel returns window centre (element 4) after KERNEL_LAT = 2.
  - Required win_o element 0 order per window: 0, 1, 4, 5.
  - Required out_ofmap = {16'h000A, 16'h0009, 16'h0006, 16'h0005}, with out_valid rising 7 cycles after E0.
- Full datapath: all ifmap elements 16'h3C00 (1.0), weights 16'h3C00, real conv_kernal. Required: all four results 9.0 (16'h4880) within 0.004.
- Backpressure: out_ready = 0 for 10 cycles in DONE. Required: out_valid and out_ofmap are stable and in_ready = 0. Dropping in_valid and pulsing in_valid during this time has no effect.
- Back-to-back with out_ready = 1: two transactions with distinct tiles. Required: second E0 occurs exactly 8 cycles after the first and both ofmaps are correct. Repeat with KERNEL_LAT = 1 and 4 for the timing scaling.
- Reset mid-FEED: assert rst_n = 0 during win_idx 2. Required: all outputs at reset values within the same cycle; no out_valid ever appears for the aborted tile; the next transaction completes correctly.
